wb_downsizer_seq: RTL

Sequential Wishbone width converter. One wide classic-cycle access from the master side becomes a series of narrow classic-cycle beats on the slave side. Read data from the beats is assembled into one wide word, and a single termination goes back to the master. It sits between a wide bus master and a narrow slave, or in front of the combinational granularity adapter. The combinational adapter only truncates or muxes lanes; this block is used wherever every byte lane must actually reach a narrower slave.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_lane_assembler.sv | 46 ++++
 rtl/wb_downsizer_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone sequential downsizer.
package wb_pkg;

    localparam int GRAN      = 8;
    localparam int GRAN_LOG2 = 3;

    typedef enum logic [1:0] {
        IDLE,
        BEAT,
        TERM
    } state_t;

    typedef enum logic [1:0] {
        TERM_ACK,
        TERM_ERR,
        TERM_RTY
    } term_t;

    function automatic int n_beats(input int master_size, input int slave_size);
        return master_size / slave_size;
    endfunction

endpackage

// File: rtl/wb_lane_assembler.sv
// Read assembly register: one byte lane per master byte, written from the
// current narrow beat and cleared when a new wide request is accepted.
module wb_lane_assembler
    import wb_pkg::*;
#(
    parameter int MASTER_PORT_SIZE = 32,
    parameter int SLAVE_PORT_SIZE  = 8,
    parameter int KW               = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          store,
    input  logic                          we,
    input  logic [KW-1:0]                 k,
    input  logic [MASTER_PORT_SIZE/GRAN-1:0] sel,
    input  logic [SLAVE_PORT_SIZE-1:0]    beat_dat,
    output logic [MASTER_PORT_SIZE-1:0]   asm_dat
);

    localparam int M_BYTES = MASTER_PORT_SIZE / GRAN;
    localparam int S_BYTES = SLAVE_PORT_SIZE / GRAN;

    logic [GRAN-1:0] lane_reg [M_BYTES];

    generate
        for (genvar gi = 0; gi < M_BYTES; gi++) begin : g_lane
            localparam int BEAT_IDX = gi / S_BYTES;
            localparam int LANE     = gi % S_BYTES;

            // Lanes with sel = 0 are never written, so they read back as zero.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg[gi] <= '0;
                end else if (clear) begin
                    lane_reg[gi] <= '0;
                end else if (store && !we && sel[gi] && (k == KW'(BEAT_IDX))) begin
                    lane_reg[gi] <= beat_dat[LANE*GRAN +: GRAN];
                end
            end

            assign asm_dat[gi*GRAN +: GRAN] = lane_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/wb_downsizer_seq.sv
// Sequential Wishbone width converter: one wide access -> N narrow beats.
// Optional WB_DOWNSIZER_SKIP_EMPTY_EN skips beats whose sel slice is zero.
module wb_downsizer_seq
    import wb_pkg::*;
#(
    parameter int MASTER_ADR_BITS  = 16,
    parameter int MASTER_PORT_SIZE = 32,
    parameter int SLAVE_ADR_BITS   = 16,
    parameter int SLAVE_PORT_SIZE  = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [MASTER_ADR_BITS-1:0]       master_adr,
    input  logic [MASTER_PORT_SIZE-1:0]      master_dat_ms,
    input  logic [MASTER_PORT_SIZE/GRAN-1:0] master_sel,
    input  logic                             master_we,
    input  logic                             master_stb,
    input  logic                             master_cyc,
    output logic [MASTER_PORT_SIZE-1:0]      master_dat_sm,
    output logic                             master_ack,
    output logic                             master_err,
    output logic                             master_rty,
    output logic [SLAVE_ADR_BITS-1:0]        slave_adr,
    output logic [SLAVE_PORT_SIZE-1:0]       slave_dat_ms,
    output logic [SLAVE_PORT_SIZE/GRAN-1:0]  slave_sel,
    output logic                             slave_we,
    output logic                             slave_stb,
    output logic                             slave_cyc,
    input  logic [SLAVE_PORT_SIZE-1:0]       slave_dat_sm,
    input  logic                             slave_ack,
    input  logic                             slave_err,
    input  logic                             slave_rty
);

    localparam int N_BEATS = n_beats(MASTER_PORT_SIZE, SLAVE_PORT_SIZE);
    localparam int M_BYTES = MASTER_PORT_SIZE / GRAN;
    localparam int S_BYTES = SLAVE_PORT_SIZE / GRAN;
    localparam int KW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    state_t                      state_reg;
    logic [KW-1:0]               k_reg;
    logic [MASTER_ADR_BITS-1:0]  base_reg;
    logic [MASTER_PORT_SIZE-1:0] dat_reg;
    logic [M_BYTES-1:0]          sel_reg;
    logic                        we_reg;

    logic [MASTER_ADR_BITS-1:0]  base_next;
    logic                        accept;
    logic                        store;
    int                          start_beat;
    int                          next_beat;
    term_t                       beat_term;

    function automatic logic [SLAVE_ADR_BITS-1:0] beat_adr(
        input logic [MASTER_ADR_BITS-1:0] base, input int j);
        logic [MASTER_ADR_BITS-1:0] a;
        a = base + MASTER_ADR_BITS'(j * S_BYTES);
        return SLAVE_ADR_BITS'(a);
    endfunction

    function automatic logic [SLAVE_PORT_SIZE-1:0] beat_dat(
        input logic [MASTER_PORT_SIZE-1:0] d, input int j);
        return d[j*SLAVE_PORT_SIZE +: SLAVE_PORT_SIZE];
    endfunction

    function automatic logic [S_BYTES-1:0] beat_sel(
        input logic [M_BYTES-1:0] s, input int j);
        return s[j*S_BYTES +: S_BYTES];
    endfunction

`ifdef WB_DOWNSIZER_SKIP_EMPTY_EN
    // First beat at or after 'from' with a non-empty sel slice; N_BEATS if none.
    function automatic int first_beat(input logic [M_BYTES-1:0] s, input int from);
        int r;
        r = N_BEATS;
        for (int j = N_BEATS - 1; j >= 0; j--) begin
            if (j >= from && s[j*S_BYTES +: S_BYTES] != '0) r = j;
        end
        return r;
    endfunction

    always_comb begin
        start_beat = first_beat(master_sel, 0);
        next_beat  = first_beat(sel_reg, int'(k_reg) + 1);
    end
`else
    always_comb begin
        start_beat = 0;
        next_beat  = int'(k_reg) + 1;
    end
`endif

    assign base_next = master_adr & ~MASTER_ADR_BITS'(M_BYTES - 1);
    assign accept    = (state_reg == IDLE) && master_cyc && master_stb;
    assign store     = (state_reg == BEAT) && master_cyc && slave_ack && !slave_err && !slave_rty;

    always_comb begin
        beat_term = TERM_ACK;
        if (slave_err)      beat_term = TERM_ERR;
        else if (slave_rty) beat_term = TERM_RTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            k_reg        <= '0;
            base_reg     <= '0;
            dat_reg      <= '0;
            sel_reg      <= '0;
            we_reg       <= 1'b0;
            slave_adr    <= '0;
            slave_dat_ms <= '0;
            slave_sel    <= '0;
            slave_we     <= 1'b0;
            slave_stb    <= 1'b0;
            slave_cyc    <= 1'b0;
            master_ack   <= 1'b0;
            master_err   <= 1'b0;
            master_rty   <= 1'b0;
        end else begin
            master_ack <= 1'b0;
            master_err <= 1'b0;
            master_rty <= 1'b0;
            case (state_reg)
                IDLE: if (accept) begin
                    base_reg <= base_next;
                    dat_reg  <= master_dat_ms;
                    sel_reg  <= master_sel;
                    we_reg   <= master_we;
                    if (start_beat >= N_BEATS) begin
                        k_reg      <= '0;
                        master_ack <= 1'b1;
                        state_reg  <= TERM;
                    end else begin
                        k_reg        <= KW'(start_beat);
                        slave_adr    <= beat_adr(base_next, start_beat);
                        slave_dat_ms <= beat_dat(master_dat_ms, start_beat);
                        slave_sel    <= beat_sel(master_sel, start_beat);
                        slave_we     <= master_we;
                        slave_cyc    <= 1'b1;
                        slave_stb    <= 1'b1;
                        state_reg    <= BEAT;
                    end
                end
                BEAT: begin
                    if (!master_cyc) begin
                        // Abort: drop the bus silently, already-acked beats stand.
                        slave_cyc <= 1'b0;
                        slave_stb <= 1'b0;
                        slave_we  <= 1'b0;
                        k_reg     <= '0;
                        state_reg <= IDLE;
                    end else if (slave_err || slave_rty || (slave_ack && next_beat >= N_BEATS)) begin
                        slave_cyc  <= 1'b0;
                        slave_stb  <= 1'b0;
                        slave_we   <= 1'b0;
                        master_ack <= (beat_term == TERM_ACK);
                        master_err <= (beat_term == TERM_ERR);
                        master_rty <= (beat_term == TERM_RTY);
                        state_reg  <= TERM;
                    end else if (slave_ack) begin
                        k_reg        <= KW'(next_beat);
                        slave_adr    <= beat_adr(base_reg, next_beat);
                        slave_dat_ms <= beat_dat(dat_reg, next_beat);
                        slave_sel    <= beat_sel(sel_reg, next_beat);
                    end
                end
                TERM: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    wb_lane_assembler #(
        .MASTER_PORT_SIZE(MASTER_PORT_SIZE),
        .SLAVE_PORT_SIZE (SLAVE_PORT_SIZE),
        .KW              (KW)
    ) u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .store   (store),
        .we      (we_reg),
        .k       (k_reg),
        .sel     (sel_reg),
        .beat_dat(slave_dat_sm),
        .asm_dat (master_dat_sm)
    );

endmodule
